// File: rtl/butterfly_pipe_if.sv
// rtl/butterfly_pipe_if.sv - sample/result handshake bundle for the radix-2 butterfly
interface butterfly_pipe_if #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 16,
    parameter int TAG_W  = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] a_re;
    logic signed [DATA_W-1:0] a_im;
    logic signed [DATA_W-1:0] b_re;
    logic signed [DATA_W-1:0] b_im;
    logic signed [TW_W-1:0]   tw_re;
    logic signed [TW_W-1:0]   tw_im;
    logic                     inv;
    logic                     scale;
    logic [TAG_W-1:0]         tag_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] y_re;
    logic signed [DATA_W-1:0] y_im;
    logic signed [DATA_W-1:0] z_re;
    logic signed [DATA_W-1:0] z_im;
    logic                     ovf;
    logic [TAG_W-1:0]         tag_out;

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, tw_re, tw_im, inv, scale, tag_in, out_ready,
        input  in_ready, out_valid, y_re, y_im, z_re, z_im, ovf, tag_out
    );

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, tw_re, tw_im, inv, scale, tag_in, out_ready,
        output in_ready, out_valid, y_re, y_im, z_re, z_im, ovf, tag_out
    );
endinterface

// File: rtl/butterfly_pipe.sv
// rtl/butterfly_pipe.sv - pipelined radix-2 DIT butterfly y=a+bW, z=a-bW, 4-cycle latency
// Macro BFLY_SATURATE_EN: clamp out-of-range results instead of wrapping.
module butterfly_pipe #(
    parameter int DATA_W = 16,
    parameter int TW_W   = 16,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    butterfly_pipe_if.slave  bus
);
    localparam int PW = DATA_W + TW_W + 1;
    localparam int SW = PW + 1;
    localparam int RW = DATA_W + 2;

    localparam logic signed [SW-1:0] C_RND = {{(SW-TW_W+1){1'b0}}, 1'b1, {(TW_W-2){1'b0}}};
    localparam logic signed [RW-1:0] C_ONE = {{(RW-1){1'b0}}, 1'b1};
    localparam logic signed [RW-1:0] C_MAX = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [RW-1:0] C_MIN = {3'b111, {(DATA_W-1){1'b0}}};

    logic                     r_s1_valid, r_s2_valid, r_s3_valid, r_s4_valid, r_s5_valid;
    logic                     r_s1_inv, r_s2_inv, r_s3_inv, r_s4_inv;
    logic                     r_s1_scale, r_s2_scale, r_s3_scale, r_s4_scale;
    logic [TAG_W-1:0]         r_s1_tag, r_s2_tag, r_s3_tag, r_s4_tag, r_s5_tag;
    logic signed [DATA_W-1:0] r_s1_a_re, r_s1_a_im, r_s2_a_re, r_s2_a_im, r_s3_a_re, r_s3_a_im;
    logic signed [DATA_W-1:0] r_s1_b_re, r_s1_b_im;
    logic signed [TW_W:0]     r_s1_tw_re, r_s1_tw_im;
    logic signed [PW-1:0]     r_s2_p_rr, r_s2_p_ii, r_s2_p_ri, r_s2_p_ir;
    logic signed [RW-1:0]     r_s3_bt_re, r_s3_bt_im;
    logic signed [RW-1:0]     r_s4_y_re, r_s4_y_im, r_s4_z_re, r_s4_z_im;
    logic signed [DATA_W-1:0] r_s5_y_re, r_s5_y_im, r_s5_z_re, r_s5_z_im;
    logic                     r_s5_ovf;

    logic                     w_en;
    logic                     w_accept;
    logic signed [TW_W:0]     w_tw_re_ext, w_tw_im_ext;
    logic signed [PW-1:0]     w_b_re_x, w_b_im_x, w_tw_re_x, w_tw_im_x;
    logic signed [SW-1:0]     w_re_rnd, w_im_rnd;
    logic [DATA_W:0]          w_fy_re, w_fy_im, w_fz_re, w_fz_im;
    logic                     w_unused;

    // Optional /2 with round half-up, then range check; returns {ovf, result}.
    function automatic logic [DATA_W:0] f_fit(input logic signed [RW-1:0] x, input logic sc);
        logic signed [RW-1:0] s;
        logic                 o;
        logic [DATA_W-1:0]    v;
        s = sc ? ((x + C_ONE) >>> 1) : x;
        o = (s > C_MAX) || (s < C_MIN);
`ifdef BFLY_SATURATE_EN
        v = !o ? s[DATA_W-1:0] : (s[RW-1] ? C_MIN[DATA_W-1:0] : C_MAX[DATA_W-1:0]);
`else
        v = s[DATA_W-1:0];
`endif
        return {o, v};
    endfunction

    assign w_en         = !r_s5_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && w_en;
    assign bus.in_ready = w_en;

    // One extra bit so that negating -1.0 for the conjugate stays exact.
    assign w_tw_re_ext = {bus.tw_re[TW_W-1], bus.tw_re};
    assign w_tw_im_ext = {bus.tw_im[TW_W-1], bus.tw_im};

    assign w_b_re_x  = PW'(r_s1_b_re);
    assign w_b_im_x  = PW'(r_s1_b_im);
    assign w_tw_re_x = PW'(r_s1_tw_re);
    assign w_tw_im_x = PW'(r_s1_tw_im);

    assign w_re_rnd = SW'(r_s2_p_rr) - SW'(r_s2_p_ii) + C_RND;
    assign w_im_rnd = SW'(r_s2_p_ri) + SW'(r_s2_p_ir) + C_RND;

    assign w_fy_re = f_fit(r_s4_y_re, r_s4_scale);
    assign w_fy_im = f_fit(r_s4_y_im, r_s4_scale);
    assign w_fz_re = f_fit(r_s4_z_re, r_s4_scale);
    assign w_fz_im = f_fit(r_s4_z_im, r_s4_scale);

    assign w_unused = ^{r_s4_inv, w_re_rnd[SW-1], w_re_rnd[TW_W-2:0],
                        w_im_rnd[SW-1], w_im_rnd[TW_W-2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0; r_s2_valid <= 1'b0; r_s3_valid <= 1'b0;
            r_s4_valid <= 1'b0; r_s5_valid <= 1'b0;
            r_s1_inv   <= 1'b0; r_s2_inv   <= 1'b0; r_s3_inv   <= 1'b0; r_s4_inv <= 1'b0;
            r_s1_scale <= 1'b0; r_s2_scale <= 1'b0; r_s3_scale <= 1'b0; r_s4_scale <= 1'b0;
            r_s1_tag   <= '0; r_s2_tag <= '0; r_s3_tag <= '0; r_s4_tag <= '0; r_s5_tag <= '0;
            r_s1_a_re  <= '0; r_s1_a_im <= '0; r_s2_a_re <= '0; r_s2_a_im <= '0;
            r_s3_a_re  <= '0; r_s3_a_im <= '0;
            r_s1_b_re  <= '0; r_s1_b_im <= '0; r_s1_tw_re <= '0; r_s1_tw_im <= '0;
            r_s2_p_rr  <= '0; r_s2_p_ii <= '0; r_s2_p_ri <= '0; r_s2_p_ir <= '0;
            r_s3_bt_re <= '0; r_s3_bt_im <= '0;
            r_s4_y_re  <= '0; r_s4_y_im <= '0; r_s4_z_re <= '0; r_s4_z_im <= '0;
            r_s5_y_re  <= '0; r_s5_y_im <= '0; r_s5_z_re <= '0; r_s5_z_im <= '0;
            r_s5_ovf   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= w_accept;
            r_s1_inv   <= bus.inv;
            r_s1_scale <= bus.scale;
            r_s1_tag   <= bus.tag_in;
            r_s1_a_re  <= bus.a_re;
            r_s1_a_im  <= bus.a_im;
            r_s1_b_re  <= bus.b_re;
            r_s1_b_im  <= bus.b_im;
            r_s1_tw_re <= w_tw_re_ext;
            r_s1_tw_im <= bus.inv ? -w_tw_im_ext : w_tw_im_ext;

            r_s2_valid <= r_s1_valid;
            r_s2_inv   <= r_s1_inv;
            r_s2_scale <= r_s1_scale;
            r_s2_tag   <= r_s1_tag;
            r_s2_a_re  <= r_s1_a_re;
            r_s2_a_im  <= r_s1_a_im;
            r_s2_p_rr  <= w_b_re_x * w_tw_re_x;
            r_s2_p_ii  <= w_b_im_x * w_tw_im_x;
            r_s2_p_ri  <= w_b_re_x * w_tw_im_x;
            r_s2_p_ir  <= w_b_im_x * w_tw_re_x;

            r_s3_valid <= r_s2_valid;
            r_s3_inv   <= r_s2_inv;
            r_s3_scale <= r_s2_scale;
            r_s3_tag   <= r_s2_tag;
            r_s3_a_re  <= r_s2_a_re;
            r_s3_a_im  <= r_s2_a_im;
            r_s3_bt_re <= w_re_rnd[TW_W-1 +: RW];
            r_s3_bt_im <= w_im_rnd[TW_W-1 +: RW];

            r_s4_valid <= r_s3_valid;
            r_s4_inv   <= r_s3_inv;
            r_s4_scale <= r_s3_scale;
            r_s4_tag   <= r_s3_tag;
            r_s4_y_re  <= RW'(r_s3_a_re) + r_s3_bt_re;
            r_s4_y_im  <= RW'(r_s3_a_im) + r_s3_bt_im;
            r_s4_z_re  <= RW'(r_s3_a_re) - r_s3_bt_re;
            r_s4_z_im  <= RW'(r_s3_a_im) - r_s3_bt_im;

            r_s5_valid <= r_s4_valid;
            r_s5_tag   <= r_s4_tag;
            r_s5_y_re  <= w_fy_re[DATA_W-1:0];
            r_s5_y_im  <= w_fy_im[DATA_W-1:0];
            r_s5_z_re  <= w_fz_re[DATA_W-1:0];
            r_s5_z_im  <= w_fz_im[DATA_W-1:0];
            r_s5_ovf   <= w_fy_re[DATA_W] | w_fy_im[DATA_W] | w_fz_re[DATA_W] | w_fz_im[DATA_W];
        end
    end

    assign bus.out_valid = r_s5_valid;
    assign bus.y_re      = r_s5_y_re;
    assign bus.y_im      = r_s5_y_im;
    assign bus.z_re      = r_s5_z_re;
    assign bus.z_im      = r_s5_z_im;
    assign bus.ovf       = r_s5_ovf;
    assign bus.tag_out   = r_s5_tag;
endmodule

// File: tb/tb_butterfly_pipe.sv
// tb/tb_butterfly_pipe.sv - randomized and directed bench for butterfly_pipe with a scoreboard model
module tb_butterfly_pipe;
    localparam int DW = 16;
    localparam int TW = 16;
    localparam int GW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    butterfly_pipe_if #(.DATA_W(DW), .TW_W(TW), .TAG_W(GW)) bus();
    butterfly_pipe #(.DATA_W(DW), .TW_W(TW), .TAG_W(GW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        longint y_re, y_im, z_re, z_im;
        longint ovf;
        longint tag;
        int     acc_cyc;
        int     stalls;
    } exp_t;

    exp_t   q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    int     stall_cnt = 0;
    int     n_out = 0;
    bit     last_acc = 1'b0;
    longint last_y_re, last_y_im, last_z_re, last_z_im, last_ovf, last_tag;

    task automatic check(input string tag, input longint got, input longint want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic longint fit(input longint s, output bit o);
        longint mx, mn;
        logic signed [DW-1:0] w;
        mx = (longint'(1) << (DW-1)) - 1;
        mn = -(longint'(1) << (DW-1));
        o  = (s > mx) || (s < mn);
`ifdef BFLY_SATURATE_EN
        if (s > mx) return mx;
        if (s < mn) return mn;
        return s;
`else
        w = s[DW-1:0];
        return longint'(w);
`endif
    endfunction

    function automatic exp_t model(input longint ar, ai, br, bi, twr, twi,
                                   input bit inv, sc, input longint tag);
        exp_t   e;
        longint ti, pre, pim, bre, bim;
        longint v[4];
        longint r[4];
        bit     o;
        ti  = inv ? -twi : twi;
        pre = br * twr - bi * ti;
        pim = br * ti + bi * twr;
        bre = (pre + (longint'(1) << (TW-2))) >>> (TW-1);
        bim = (pim + (longint'(1) << (TW-2))) >>> (TW-1);
        v = '{ar + bre, ai + bim, ar - bre, ai - bim};
        e.ovf = 0;
        for (int i = 0; i < 4; i++) begin
            if (sc) v[i] = (v[i] + 1) >>> 1;
            r[i] = fit(v[i], o);
            if (o) e.ovf = 1;
        end
        e.y_re = r[0]; e.y_im = r[1]; e.z_re = r[2]; e.z_im = r[3];
        e.tag = tag; e.acc_cyc = 0; e.stalls = 0;
        return e;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out", 1, 0);
                end else begin
                    e = q[0];
                    check("y_re", bus.y_re, e.y_re);
                    check("y_im", bus.y_im, e.y_im);
                    check("z_re", bus.z_re, e.z_re);
                    check("z_im", bus.z_im, e.z_im);
                    check("ovf", bus.ovf, e.ovf);
                    check("tag", bus.tag_out, e.tag);
                    if (bus.out_ready) begin
                        check("latency", cyc - (e.acc_cyc + 1), 4 + stall_cnt - e.stalls);
                        last_y_re = bus.y_re; last_y_im = bus.y_im;
                        last_z_re = bus.z_re; last_z_im = bus.z_im;
                        last_ovf  = bus.ovf;  last_tag  = bus.tag_out;
                        n_out++;
                        void'(q.pop_front());
                    end
                end
            end
            if (bus.out_valid && !bus.out_ready) stall_cnt++;
            last_acc = bus.in_valid && bus.in_ready;
            if (last_acc) begin
                e = model(bus.a_re, bus.a_im, bus.b_re, bus.b_im, bus.tw_re, bus.tw_im,
                          bus.inv, bus.scale, bus.tag_in);
                e.acc_cyc = cyc;
                e.stalls  = stall_cnt;
                q.push_back(e);
            end
        end else begin
            last_acc = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int ar, ai, br, bi, twr, twi, input bit inv, sc, input int tag);
        bus.a_re = DW'(ar);   bus.a_im = DW'(ai);
        bus.b_re = DW'(br);   bus.b_im = DW'(bi);
        bus.tw_re = TW'(twr); bus.tw_im = TW'(twi);
        bus.inv = inv; bus.scale = sc; bus.tag_in = GW'(tag);
    endtask

    function automatic int rval();
        logic signed [DW-1:0] t;
        case ($urandom_range(7))
            0: t = {1'b1, {(DW-1){1'b0}}};
            1: t = {1'b0, {(DW-1){1'b1}}};
            2: t = '0;
            default: t = DW'($urandom);
        endcase
        return int'(t);
    endfunction

    task automatic set_random(input int tag);
        set_in(rval(), rval(), rval(), rval(), rval(), rval(),
               1'($urandom_range(1)), 1'($urandom_range(1)), tag);
    endtask

    task automatic send(input int ar, ai, br, bi, twr, twi, input bit inv, sc, input int tag);
        bit ok;
        ok = 1'b0;
        set_in(ar, ai, br, bi, twr, twi, inv, sc, tag);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (last_acc) begin ok = 1'b1; break; end
        end
        if (!ok) check("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            if (q.size() == 0) break;
            tick();
        end
        check("drain", q.size(), 0);
        repeat (6) tick();
    endtask

    task automatic rand_stream(input int n, input int pv, input int pr);
        for (int i = 0; i < n; i++) begin
            tick();
            if (!bus.in_valid || last_acc) begin
                if (int'($urandom_range(99)) < pv) begin
                    set_random(int'($urandom_range(255)));
                    bus.in_valid = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = int'($urandom_range(99)) < pr;
        end
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        int  out_before;
        bit  found;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_y_re", bus.y_re, 0);
        check("rst_z_im", bus.z_im, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_tag", bus.tag_out, 0);
        rst = 1'b0;
        tick();
        check("rst_in_ready", bus.in_ready, 1);

        send(1000, 0, 2000, 0, 32767, 0, 1'b0, 1'b0, 8'h5A);
        drain();
        check("basic_y_re", last_y_re, 3000);
        check("basic_y_im", last_y_im, 0);
        check("basic_z_re", last_z_re, -1000);
        check("basic_z_im", last_z_im, 0);
        check("basic_ovf", last_ovf, 0);
        check("basic_tag", last_tag, 8'h5A);

        send(0, 0, 0, 1000, 0, -32768, 1'b0, 1'b0, 1);
        drain();
        check("fwd_y_re", last_y_re, 1000);
        check("fwd_y_im", last_y_im, 0);
        check("fwd_z_re", last_z_re, -1000);
        send(0, 0, 0, 1000, 0, -32768, 1'b1, 1'b0, 2);
        drain();
        check("inv_y_re", last_y_re, -1000);
        check("inv_y_im", last_y_im, 0);
        check("inv_z_re", last_z_re, 1000);

        send(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b0, 3);
        drain();
        check("ovf_flag", last_ovf, 1);
        check("ovf_z_re", last_z_re, 1);
`ifdef BFLY_SATURATE_EN
        check("ovf_y_re", last_y_re, 32767);
`else
        check("ovf_y_re", last_y_re, -3);
`endif
        send(32767, 0, 32767, 0, 32767, 0, 1'b0, 1'b1, 4);
        drain();
        check("scl_y_re", last_y_re, 32767);
        check("scl_y_im", last_y_im, 0);
        check("scl_z_re", last_z_re, 1);
        check("scl_ovf", last_ovf, 0);

        out_before = n_out;
        found = 1'b0;
        fork
            begin
                for (int t = 0; t < 8; t++)
                    send(rval(), rval(), rval(), rval(), rval(), rval(),
                         1'($urandom_range(1)), 1'($urandom_range(1)), t);
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    tick();
                    if (bus.out_valid && bus.tag_out == 1) begin found = 1'b1; break; end
                end
                if (found) begin
                    bus.out_ready = 1'b0;
                    for (int k = 0; k < 5; k++) begin
                        tick();
                        check("bp_in_ready", bus.in_ready, 0);
                        check("bp_hold_tag", bus.tag_out, 1);
                    end
                    bus.out_ready = 1'b1;
                end
            end
        join
        check("bp_tag1_seen", found, 1);
        drain();
        check("bp_delivered", n_out - out_before, 8);

        rand_stream(10, 100, 100);
        #3;
        rst = 1'b1;
        #1;
        check("mrst_out_valid", bus.out_valid, 0);
        check("mrst_y_re", bus.y_re, 0);
        check("mrst_y_im", bus.y_im, 0);
        check("mrst_z_re", bus.z_re, 0);
        check("mrst_ovf", bus.ovf, 0);
        check("mrst_tag", bus.tag_out, 0);
        q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        out_before = n_out;
        send(1234, -77, 500, 600, 20000, -15000, 1'b1, 1'b0, 8'hAA);
        drain();
        check("mrst_delivered", n_out - out_before, 1);
        check("mrst_tag_out", last_tag, 8'hAA);

        out_before = n_out;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                set_random(100 + i);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        drain();
        check("bubble_delivered", n_out - out_before, 8);

        rand_stream(400, 70, 70);
        drain();
        rand_stream(300, 100, 50);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
